fp_mul_seq: RTL and testbench
=============================

# fp_mul_seq

Parametrised, multi-cycle IEEE-754-style floating-point multiplier that extends the combinational half-precision multiply box. It adds configurable exponent/mantissa widths, subnormal input normalisation, round-to-nearest-even, special-value handling, sticky-free per-result status flags and a valid/ready handshake on both sides. It sits between the operand issue logic and the result writeback stage, processing one operation at a time.

## Interface
- EXP_W, 5, exponent field width (≥3)
- MAN_W, 10, explicit mantissa field width (≥2); word width W = 1+EXP_W+MAN_W, BIAS = 2^(EXP_W-1)-1
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- a, b  in  W  operands {sign, exp, mantissa}
- out_valid  out  1  result and flags valid
- out_ready  in  1  downstream accepts result
- result  out  W  product
- inf, zero, nan  out  1 each  result class
- overflow, underflow, inexact  out  1 each  exception flags for this result

## Operation
- Reset: state IDLE, out_valid=0, result=0, all flags=0; in_ready=1 on first cycle after reset release. Reset mid-operation abandons the operation; nothing is emitted.
- Accept when in_valid && in_ready; operands registered; sign = a[W-1]^b[W-1].
- IDLE → UNPACK (1 cycle): classify operands.
  - Either NaN, or inf×0 → canonical qNaN {0, all-ones exp, 1, zeros}, nan=1 → DONE.
  - Either inf (other nonzero) → {sign, all-ones, 0}, inf=1 → DONE.
  - Either zero → {sign, 0}, zero=1 → DONE.
  - Else: significand = {hidden, man}, hidden=1 for normal, 0 for subnormal; subnormal effective exponent = 1. → NORM if any hidden bit is 0, else MUL.
- NORM: each cycle, every operand whose hidden bit is 0 shifts left 1 and decrements its exponent; both operands shift in parallel. → MUL when both hidden bits set.
- MUL: radix-2 shift-add, one multiplier bit per cycle, exactly MAN_W+1 cycles, 2*(MAN_W+1)-bit product. Exponent accumulator signed, EXP_W+2 bits: e = ea+eb-BIAS.
- ROUND (1 cycle): if product MSB set, shift right 1 / e+1. Keep MAN_W+1 bits, guard = next bit, sticky = OR of remainder. Round to nearest, ties to even; rounding carry-out renormalises (e+1). inexact = guard|sticky.
  - e ≥ 2^EXP_W-1 → {sign, inf}, overflow=1, inf=1, inexact=1.
  - e ≤ 0 → flush to {sign, 0}, underflow=1, zero=1, inexact=1 (no subnormal outputs).
  - Else normal result.
- DONE: out_valid=1; result/flags held stable until out_valid && out_ready, then → IDLE.

## Timing
- Accept edge = T. Specials: out_valid from T+2. Normal×normal: UNPACK T+1, MUL T+2..T+MAN_W+2, ROUND T+MAN_W+3, out_valid from T+MAN_W+4 (14 for default). Subnormals add k cycles, k = larger leading-zero count of the two significands.
- in_ready is combinational from state only; no combinational path in_valid→in_ready or out_ready→out_valid.
- Handshake completes on edge with out_valid && out_ready; in_ready=1 next cycle; back-to-back throughput = latency+1.
- out_ready held low: outputs stable indefinitely, in_ready stays 0, input ignored.
- Flags deasserted whenever out_valid=0.

## Test plan
- 0x3E00 × 0x4000 (1.5×2.0) → 0x4200, no flags, out_valid exactly 14 cycles after accept; 0xC000 × 0x4200 → 0xC600.
- 0x7BFF × 0x7BFF → 0x7C00, inf=overflow=inexact=1; 0x7C00 × 0x0000 → 0x7E00, nan=1, out_valid at T+2.
- 0x0001 × 0x6400 (2^-24×1024) → 0x0400, no flags, 10 NORM cycles (out_valid at T+24).
- 0x3C01 × 0x3C01 → 0x3C02, inexact=1; 0x0400 × 0x0400 → 0x0000, zero=underflow=inexact=1.
- Backpressure: out_ready low 5 cycles after out_valid → result/flags unchanged, in_ready=0, in_valid pulses ignored; out_ready high → in_ready=1 next cycle.
- rst_n low during MUL → out_valid=0, result=0 immediately; after release in_ready=1 and next op 0x3C00×0x3C00 → 0x3C00.

Source files
------------

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multi-cycle IEEE-754-style multiplier with subnormal input normalisation,
// shift-add significand multiply and round-to-nearest-even. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module fp_mul_seq #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic                   inf,
   output logic                   zero,
   output logic                   nan,
   output logic                   overflow,
   output logic                   underflow,
   output logic                   inexact
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int SW   = MAN_W + 1;
   localparam int PW   = 2 * SW;
   localparam int EW   = EXP_W + 2;
   localparam int CW   = $clog2(SW + 1);
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;

   localparam logic [EW:0]  c_EBIAS = (EW + 1)'(BIAS);
   localparam logic [EW:0]  c_EOVF  = (EW + 1)'((1 << EXP_W) - 1);
   localparam logic [W-1:0] c_QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_NORM   = 3'd2,
      S_MUL    = 3'd3,
      S_ROUND  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t          r_state;
   logic [W-1:0]    r_a, r_b;
   logic [SW-1:0]   r_ma, r_mb;
   logic [EW-1:0]   r_ea, r_eb;
   logic [PW-1:0]   r_prod;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_result;
   logic            r_out_valid;
   logic            r_inf, r_zero, r_nan, r_ovf, r_unf, r_inx;

   logic            w_sign;
   logic [EXP_W-1:0] w_exp_a, w_exp_b;
   logic [MAN_W-1:0] w_man_a, w_man_b;
   logic            w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   logic            w_is_nan, w_is_inf, w_is_zero;
   logic [SW-1:0]   w_sig_a, w_sig_b;
   logic [EW-1:0]   w_ea0, w_eb0;
   logic [SW-1:0]   w_ma_n, w_mb_n;
   logic [EW-1:0]   w_ea_n, w_eb_n;
   logic [SW:0]     w_sum;
   logic [PW-2:0]   w_pn;
   logic [MAN_W-1:0] w_kept;
   logic            w_guard, w_sticky, w_rup;
   logic [MAN_W:0]  w_rnd;
   logic [EW:0]     w_ef;
   logic            w_ovf, w_unf;

   // Operand classification
   always_comb begin
      w_sign    = r_a[W-1] ^ r_b[W-1];
      w_exp_a   = r_a[W-2:MAN_W];
      w_exp_b   = r_b[W-2:MAN_W];
      w_man_a   = r_a[MAN_W-1:0];
      w_man_b   = r_b[MAN_W-1:0];
      w_a_nan   = (w_exp_a == {EXP_W{1'b1}}) && (w_man_a != '0);
      w_b_nan   = (w_exp_b == {EXP_W{1'b1}}) && (w_man_b != '0);
      w_a_inf   = (w_exp_a == {EXP_W{1'b1}}) && (w_man_a == '0);
      w_b_inf   = (w_exp_b == {EXP_W{1'b1}}) && (w_man_b == '0);
      w_a_zero  = (w_exp_a == '0) && (w_man_a == '0);
      w_b_zero  = (w_exp_b == '0) && (w_man_b == '0);
      w_is_nan  = w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf);
      w_is_inf  = w_a_inf || w_b_inf;
      w_is_zero = w_a_zero || w_b_zero;
      w_sig_a   = {(w_exp_a != '0), w_man_a};
      w_sig_b   = {(w_exp_b != '0), w_man_b};
      w_ea0     = (w_exp_a == '0) ? EW'(1) : {2'b00, w_exp_a};
      w_eb0     = (w_exp_b == '0) ? EW'(1) : {2'b00, w_exp_b};
   end

   // Normalisation step, multiply step and rounding datapath
   always_comb begin
      w_ma_n   = r_ma[SW-1] ? r_ma : {r_ma[SW-2:0], 1'b0};
      w_mb_n   = r_mb[SW-1] ? r_mb : {r_mb[SW-2:0], 1'b0};
      w_ea_n   = r_ma[SW-1] ? r_ea : r_ea - EW'(1);
      w_eb_n   = r_mb[SW-1] ? r_eb : r_eb - EW'(1);
      w_sum    = {1'b0, r_prod[PW-1:SW]} + (r_prod[0] ? {1'b0, r_ma} : {(SW+1){1'b0}});
      // Product lies in [1,4); drop the leading one after aligning it to bit PW-1
      w_pn     = r_prod[PW-1] ? r_prod[PW-2:0] : {r_prod[PW-3:0], 1'b0};
      w_kept   = w_pn[PW-2 -: MAN_W];
      w_guard  = w_pn[SW-1];
      w_sticky = |w_pn[SW-2:0];
      w_rup    = w_guard && (w_sticky || w_kept[0]);
      w_rnd    = {1'b0, w_kept} + {{MAN_W{1'b0}}, w_rup};
      w_ef     = {r_ea[EW-1], r_ea} + {r_eb[EW-1], r_eb} - c_EBIAS
               + {{EW{1'b0}}, r_prod[PW-1]} + {{EW{1'b0}}, w_rnd[MAN_W]};
      w_unf    = w_ef[EW] || (w_ef == '0);
      w_ovf    = !w_ef[EW] && (w_ef >= c_EOVF);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_ma        <= '0;
         r_mb        <= '0;
         r_ea        <= '0;
         r_eb        <= '0;
         r_prod      <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_out_valid <= 1'b0;
         r_inf       <= 1'b0;
         r_zero      <= 1'b0;
         r_nan       <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
         r_inx       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_state <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               if (w_is_nan) begin
                  r_result    <= c_QNAN;
                  r_nan       <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else if (w_is_inf) begin
                  r_result    <= {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  r_inf       <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else if (w_is_zero) begin
                  r_result    <= {w_sign, {(W-1){1'b0}}};
                  r_zero      <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_ma    <= w_sig_a;
                  r_mb    <= w_sig_b;
                  r_ea    <= w_ea0;
                  r_eb    <= w_eb0;
                  r_prod  <= {{SW{1'b0}}, w_sig_b};
                  r_cnt   <= '0;
                  r_state <= (w_sig_a[SW-1] && w_sig_b[SW-1]) ? S_MUL : S_NORM;
               end
            end
            S_NORM: begin
               r_ma   <= w_ma_n;
               r_mb   <= w_mb_n;
               r_ea   <= w_ea_n;
               r_eb   <= w_eb_n;
               r_prod <= {{SW{1'b0}}, w_mb_n};
               r_cnt  <= '0;
               if (w_ma_n[SW-1] && w_mb_n[SW-1]) begin
                  r_state <= S_MUL;
               end
            end
            S_MUL: begin
               // Low half holds the remaining multiplier bits, LSB first
               r_prod <= {w_sum, r_prod[SW-1:1]};
               r_cnt  <= r_cnt + CW'(1);
               if (r_cnt == CW'(SW - 1)) begin
                  r_state <= S_ROUND;
               end
            end
            S_ROUND: begin
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
               if (w_ovf) begin
                  r_result <= {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  r_inf    <= 1'b1;
                  r_ovf    <= 1'b1;
                  r_inx    <= 1'b1;
               end else if (w_unf) begin
                  r_result <= {w_sign, {(W-1){1'b0}}};
                  r_zero   <= 1'b1;
                  r_unf    <= 1'b1;
                  r_inx    <= 1'b1;
               end else begin
                  r_result <= {w_sign, w_ef[EXP_W-1:0], w_rnd[MAN_W-1:0]};
                  r_inx    <= w_guard || w_sticky;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_result    <= '0;
                  r_inf       <= 1'b0;
                  r_zero      <= 1'b0;
                  r_nan       <= 1'b0;
                  r_ovf       <= 1'b0;
                  r_unf       <= 1'b0;
                  r_inx       <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign inf       = r_inf;
   assign zero      = r_zero;
   assign nan       = r_nan;
   assign overflow  = r_ovf;
   assign underflow = r_unf;
   assign inexact   = r_inx;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed vectors for fp_mul_seq (half precision) with a queue-based scoreboard.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_fp_mul_seq;

   localparam logic [5:0] F_INF  = 6'b100000;
   localparam logic [5:0] F_ZERO = 6'b010000;
   localparam logic [5:0] F_NAN  = 6'b001000;
   localparam logic [5:0] F_OVF  = 6'b000100;
   localparam logic [5:0] F_UNF  = 6'b000010;
   localparam logic [5:0] F_INX  = 6'b000001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] op_a, op_b, result;
   logic        inf, zero, nan, overflow, underflow, inexact;
   logic [5:0]  flags;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [5:0]  fl;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic        seen    = 1'b0;
   int          first_cyc = 0;
   logic [21:0] snap;

   fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .a(op_a), .b(op_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .inf(inf), .zero(zero), .nan(nan),
      .overflow(overflow), .underflow(underflow), .inexact(inexact)
   );

   assign flags = {inf, zero, nan, overflow, underflow, inexact};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   // Monitor: samples on the falling edge, pops the scoreboard on each handshake
   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 1'b0;
      end else if (out_valid) begin
         if (!seen) begin
            seen      = 1'b1;
            first_cyc = cyc;
            snap      = {result, flags};
         end else begin
            chk("hold_stable", {10'd0, result, flags}, {10'd0, snap});
         end
         chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
         if (out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk($sformatf("result_%h_x_%h", e.a, e.b), {16'd0, result}, {16'd0, e.res});
               chk($sformatf("flags_%h_x_%h", e.a, e.b), {26'd0, flags}, {26'd0, e.fl});
               chk($sformatf("latency_%h_x_%h", e.a, e.b), first_cyc - e.acc + 1, e.lat);
            end
            seen = 1'b0;
         end
      end else begin
         seen = 1'b0;
         chk("flags_idle", {26'd0, flags}, 32'd0);
      end
   end

   // Driver: all changes happen 1 time unit after a rising edge
   task automatic issue(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input logic [5:0] fl, input int lat);
      exp_t e;
      int   k = 0;
      while (!in_ready && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (!in_ready) begin
         chk("issue_timeout", 32'd1, 32'd0);
         return;
      end
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      e.a = a; e.b = b; e.res = res; e.fl = fl; e.lat = lat; e.acc = cyc;
      q.push_back(e);
   endtask

   task automatic drain();
      int k = 0;
      while ((q.size() != 0 || out_valid) && k < 2000) begin
         @(posedge clk); #1;
         k++;
      end
      if (q.size() != 0 || out_valid) chk("drain_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int k;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op_a      = '0;
      op_b      = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", {16'd0, result}, 32'd0);
      chk("rst_flags", {26'd0, flags}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      issue(16'h3E00, 16'h4000, 16'h4200, 6'd0, 14);
      issue(16'hC000, 16'h4200, 16'hC600, 6'd0, 14);
      issue(16'h7BFF, 16'h7BFF, 16'h7C00, F_INF | F_OVF | F_INX, 14);
      issue(16'h7C00, 16'h0000, 16'h7E00, F_NAN, 2);
      issue(16'h0001, 16'h6400, 16'h0400, 6'd0, 24);
      issue(16'h3C01, 16'h3C01, 16'h3C02, F_INX, 14);
      issue(16'h0400, 16'h0400, 16'h0000, F_ZERO | F_UNF | F_INX, 14);
      issue(16'h7C00, 16'hC000, 16'hFC00, F_INF, 2);
      issue(16'h8000, 16'h3C00, 16'h8000, F_ZERO, 2);
      issue(16'h7C01, 16'h3C00, 16'h7E00, F_NAN, 2);
      issue(16'h3C01, 16'h3E00, 16'h3E02, F_INX, 14);
      issue(16'h3C03, 16'h3E00, 16'h3E04, F_INX, 14);
      issue(16'h7BFF, 16'h3C00, 16'h7BFF, 6'd0, 14);
      issue(16'h0400, 16'h3C00, 16'h0400, 6'd0, 14);
      issue(16'h0200, 16'h0200, 16'h0000, F_ZERO | F_UNF | F_INX, 15);
      issue(16'h8400, 16'h0400, 16'h8000, F_ZERO | F_UNF | F_INX, 14);
      drain();

      // Backpressure: result must hold while extra requests are ignored
      out_ready = 1'b0;
      issue(16'h3E00, 16'h4000, 16'h4200, 6'd0, 14);
      k = 0;
      while (!out_valid && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      repeat (5) begin
         in_valid = 1'b1;
         op_a     = 16'h3C00;
         op_b     = 16'h3C00;
         chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
      chk("bp_out_valid_after", {31'd0, out_valid}, 32'd0);
      drain();

      // Reset in the middle of the multiply
      in_valid = 1'b1;
      op_a     = 16'h3C00;
      op_b     = 16'h4000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_result", {16'd0, result}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
      issue(16'h3C00, 16'h3C00, 16'h3C00, 6'd0, 14);
      drain();
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
